// File: rtl/ui_debounce.sv
// ui_debounce: input conditioning for the demo-board ui_in pins.
// Each bit is brought into the clock domain by a two-flop synchroniser.
// A per-bit stability counter then debounces it. Finally it is turned into a
// registered clean level plus one-cycle rise/fall pulses. An 8-bit wrapping
// counter tallies the cycles in which at least one bit produced a rise.
module ui_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [7:0]       evt_count
);

  // The terminal count is reached after DEBOUNCE_CYCLES-1 increments.
  // The edge that sees the terminal count is the DEBOUNCE_CYCLES-th
  // consecutive cycle of disagreement, and that edge commits the new level.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] clean_next;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_next;
  logic [7:0]       evt_next;

  // Two-flop synchroniser. It runs independently of ena, so the sampled view
  // of the pins is current as soon as the design is re-enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  // Per-bit debounce decision. Pulses default low, so they last exactly one
  // cycle. While ena is low, every counter and level simply holds.
  always_comb begin
    clean_next = clean_out;
    rise_next  = '0;
    fall_next  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = cnt[i];
    end
    if (ena) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == clean_out[i]) begin
          cnt_next[i] = '0;
        end else if (cnt[i] != CNT_MAX) begin
          cnt_next[i] = cnt[i] + 1'b1;
        end else begin
          cnt_next[i]   = '0;
          clean_next[i] = s2[i];
          rise_next[i]  = s2[i];
          fall_next[i]  = ~s2[i];
        end
      end
    end
  end

  // The event count advances once per cycle that has any rise, however many
  // bits rose together. It wraps naturally at 8 bits.
  always_comb begin
    evt_next = evt_count;
    if (|rise_next) begin
      evt_next = evt_count + 8'd1;
    end
  end

  // Debounce state and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      clean_out  <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
      evt_count  <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
      clean_out  <= clean_next;
      rise_pulse <= rise_next;
      fall_pulse <= fall_next;
      evt_count  <= evt_next;
    end
  end

endmodule
